// File: rtl/button_pkg.sv
// Shared types for the button gesture decoder: FSM states and bundled event pulses.
package button_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DOWN1,
        GAP,
        DOWN2,
        LONG
    } btn_state_t;

    // 'release' is a reserved word, so the release pulse is carried as 'rel'.
    typedef struct packed {
        logic press;
        logic rel;
        logic click;
        logic dbl;
        logic long;
    } btn_evt_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_events_edge_det.sv
// Registers the (optionally inverted) level and flags rising/falling transitions against it.
module edge_det #(
    parameter bit INVERT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o,
    output logic level_o
);

    logic lvl;
    logic prev_d;
    logic prev_q;

    assign lvl    = d_i ^ INVERT;
    assign prev_d = lvl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise_o  = lvl & ~prev_q;
    assign fall_o  = ~lvl & prev_q;
    assign level_o = prev_q;

endmodule

// File: rtl/button_events.sv
// Gesture decoder: turns a debounced button level into press/release/click/double/long pulses.
module button_events #(
    parameter int LONG_TICKS   = 50000000,
    parameter int DOUBLE_TICKS = 12500000,
    parameter int INVERT       = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i,
    output logic held_o,
    output logic press_o,
    output logic release_o,
    output logic click_o,
    output logic dbl_o,
    output logic long_o
);

    import button_pkg::*;

    localparam int CW = $clog2(max2(LONG_TICKS, DOUBLE_TICKS) + 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] DBL_LAST  = (DOUBLE_TICKS == 0) ? '0 : CW'(DOUBLE_TICKS - 1);
    localparam logic [CW-1:0] CTR_MAX   = '1;

    logic       rise;
    logic       fall;
    logic       level;
    btn_state_t state_q, state_d;
    logic [CW-1:0] ctr_q, ctr_d, ctr_inc;
    btn_evt_t   evt_q, evt_d;

    edge_det #(
        .INVERT(INVERT != 0)
    ) u_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (i),
        .rise_o (rise),
        .fall_o (fall),
        .level_o(level)
    );

    assign ctr_inc = (ctr_q == CTR_MAX) ? ctr_q : ctr_q + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            evt_q   <= evt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = DOWN1;
                    ctr_d   = '0;
                end
            end
            DOWN1: begin
                if (fall) begin
                    state_d = (DOUBLE_TICKS != 0) ? GAP : IDLE;
                    ctr_d   = '0;
                end else if (ctr_q == LONG_LAST) begin
                    state_d = LONG;
                end else begin
                    ctr_d = ctr_inc;
                end
            end
            GAP: begin
                if (rise) begin
                    state_d = DOWN2;
                    ctr_d   = '0;
                end else if (ctr_q == DBL_LAST) begin
                    state_d = IDLE;
                end else begin
                    ctr_d = ctr_inc;
                end
            end
            DOWN2: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (ctr_q == LONG_LAST) begin
                    state_d = LONG;
                end else begin
                    ctr_d = ctr_inc;
                end
            end
            LONG: begin
                if (fall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A long second press still credits the first click.
    always_comb begin
        evt_d = '0;
        unique case (state_q)
            IDLE:  evt_d.press = rise;
            DOWN1: begin
                if (fall) begin
                    evt_d.rel   = 1'b1;
                    evt_d.click = (DOUBLE_TICKS == 0);
                end else if (ctr_q == LONG_LAST) begin
                    evt_d.long = 1'b1;
                end
            end
            GAP: begin
                if (rise) begin
                    evt_d.press = 1'b1;
                end else if (ctr_q == DBL_LAST) begin
                    evt_d.click = 1'b1;
                end
            end
            DOWN2: begin
                if (fall) begin
                    evt_d.rel = 1'b1;
                    evt_d.dbl = 1'b1;
                end else if (ctr_q == LONG_LAST) begin
                    evt_d.click = 1'b1;
                    evt_d.long  = 1'b1;
                end
            end
            LONG:    evt_d.rel = fall;
            default: evt_d = '0;
        endcase
    end

    assign held_o    = level;
    assign press_o   = evt_q.press;
    assign release_o = evt_q.rel;
    assign click_o   = evt_q.click;
    assign dbl_o     = evt_q.dbl;
    assign long_o    = evt_q.long;

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: directed gesture scenarios plus a timestamp-based reference model.
module tb_button_events;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_a = 1'b0;
    logic i_b = 1'b1;

    logic a_held, a_press, a_rel, a_click, a_dbl, a_long;
    logic b_held, b_press, b_rel, b_click, b_dbl, b_long;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_events #(.LONG_TICKS(8), .DOUBLE_TICKS(5), .INVERT(0)) dut_a (
        .clk(clk), .rst(rst), .i(i_a),
        .held_o(a_held), .press_o(a_press), .release_o(a_rel),
        .click_o(a_click), .dbl_o(a_dbl), .long_o(a_long)
    );

    button_events #(.LONG_TICKS(8), .DOUBLE_TICKS(0), .INVERT(1)) dut_b (
        .clk(clk), .rst(rst), .i(i_b),
        .held_o(b_held), .press_o(b_press), .release_o(b_rel),
        .click_o(b_click), .dbl_o(b_dbl), .long_o(b_long)
    );

    // Reference model: gestures described by press/release timestamps rather than states.
    typedef struct {
        bit prev;
        bit pend;
        bit long_done;
        int npress;
        int t_press;
        int t_rel;
    } ms_t;

    ms_t ma, mb;
    logic [4:0] ea, eb;
    int ncyc = 0;

    // e = {press, release, click, dbl, long}
    function automatic void model_step(inout ms_t s, input bit lvl, input int now,
                                       input int L, input int D, output logic [4:0] e);
        e = '0;
        if (lvl && !s.prev) begin
            e[4] = 1'b1;
            s.npress = s.pend ? 2 : 1;
            s.pend = 1'b0;
            s.t_press = now;
            s.long_done = 1'b0;
        end else if (!lvl && s.prev) begin
            e[3] = 1'b1;
            if (!s.long_done) begin
                if (s.npress == 2) e[1] = 1'b1;
                else if (D == 0) e[2] = 1'b1;
                else begin
                    s.pend = 1'b1;
                    s.t_rel = now;
                end
            end
        end else if (lvl) begin
            if (!s.long_done && (now - s.t_press == L)) begin
                e[0] = 1'b1;
                s.long_done = 1'b1;
                if (s.npress == 2) e[2] = 1'b1;
            end
        end else begin
            if (s.pend && (now - s.t_rel == D)) begin
                e[2] = 1'b1;
                s.pend = 1'b0;
            end
        end
        s.prev = lvl;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ma = '{default: 0};
            mb = '{default: 0};
            ea = '0;
            eb = '0;
        end else begin
            model_step(ma, i_a, ncyc, 8, 5, ea);
            model_step(mb, ~i_b, ncyc, 8, 0, eb);
        end
        ncyc++;
        #1;
        checks++;
        if ({a_press, a_rel, a_click, a_dbl, a_long} !== ea) begin
            errors++;
            $display("FAIL model_a_events cyc=%0d: got %b expected %b", ncyc,
                     {a_press, a_rel, a_click, a_dbl, a_long}, ea);
        end
        checks++;
        if (a_held !== ma.prev) begin
            errors++;
            $display("FAIL model_a_held cyc=%0d: got %b expected %b", ncyc, a_held, ma.prev);
        end
        checks++;
        if ({b_press, b_rel, b_click, b_dbl, b_long} !== eb) begin
            errors++;
            $display("FAIL model_b_events cyc=%0d: got %b expected %b", ncyc,
                     {b_press, b_rel, b_click, b_dbl, b_long}, eb);
        end
        checks++;
        if (b_held !== mb.prev) begin
            errors++;
            $display("FAIL model_b_held cyc=%0d: got %b expected %b", ncyc, b_held, mb.prev);
        end
    end

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            i_a = 1'b0;
            i_b = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({a_held, a_press, a_rel, a_click, a_dbl, a_long} !== 6'b0) begin
            errors++;
            $display("FAIL reset_a: got %b expected 000000",
                     {a_held, a_press, a_rel, a_click, a_dbl, a_long});
        end
        checks++;
        if ({b_held, b_press, b_rel, b_click, b_dbl, b_long} !== 6'b0) begin
            errors++;
            $display("FAIL reset_b: got %b expected 000000",
                     {b_held, b_press, b_rel, b_click, b_dbl, b_long});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_click();
        logic [4:0] exp;
        settle(12);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            i_a = (k >= 10 && k <= 12);
            i_b = ~i_a;
            @(posedge clk);
            #1;
            exp = {k == 10, k == 13, k == 18, 1'b0, 1'b0};
            checks++;
            if ({a_press, a_rel, a_click, a_dbl, a_long} !== exp) begin
                errors++;
                $display("FAIL single_click edge=%0d: got %b expected %b", k,
                         {a_press, a_rel, a_click, a_dbl, a_long}, exp);
            end
        end
    endtask

    task automatic test_long_press();
        logic [4:0] exp;
        settle(12);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            i_a = (k >= 10 && k <= 19);
            i_b = ~i_a;
            @(posedge clk);
            #1;
            exp = {k == 10, k == 20, 1'b0, 1'b0, k == 18};
            checks++;
            if ({a_press, a_rel, a_click, a_dbl, a_long} !== exp) begin
                errors++;
                $display("FAIL long_press edge=%0d: got %b expected %b", k,
                         {a_press, a_rel, a_click, a_dbl, a_long}, exp);
            end
        end
    endtask

    task automatic test_double_click();
        logic [4:0] exp;
        settle(12);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            i_a = (k >= 10 && k <= 11) || (k >= 15 && k <= 16);
            i_b = ~i_a;
            @(posedge clk);
            #1;
            exp = {k == 10 || k == 15, k == 12 || k == 17, 1'b0, k == 17, 1'b0};
            checks++;
            if ({a_press, a_rel, a_click, a_dbl, a_long} !== exp) begin
                errors++;
                $display("FAIL double_click edge=%0d: got %b expected %b", k,
                         {a_press, a_rel, a_click, a_dbl, a_long}, exp);
            end
        end
    endtask

    task automatic test_gap_boundary();
        logic [4:0] exp;
        settle(12);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            i_a = (k >= 10 && k <= 11) || (k >= 17 && k <= 18);
            i_b = ~i_a;
            @(posedge clk);
            #1;
            exp = {k == 10 || k == 17, k == 12 || k == 19, 1'b0, k == 19, 1'b0};
            checks++;
            if ({a_press, a_rel, a_click, a_dbl, a_long} !== exp) begin
                errors++;
                $display("FAIL gap_edge_in edge=%0d: got %b expected %b", k,
                         {a_press, a_rel, a_click, a_dbl, a_long}, exp);
            end
        end
        settle(12);
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            i_a = (k >= 10 && k <= 11) || (k >= 18 && k <= 19);
            i_b = ~i_a;
            @(posedge clk);
            #1;
            exp = {k == 10 || k == 18, k == 12 || k == 20, k == 17 || k == 25, 1'b0, 1'b0};
            checks++;
            if ({a_press, a_rel, a_click, a_dbl, a_long} !== exp) begin
                errors++;
                $display("FAIL gap_edge_out edge=%0d: got %b expected %b", k,
                         {a_press, a_rel, a_click, a_dbl, a_long}, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] exp;
        settle(12);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            i_a = (k >= 10 && k <= 21);
            i_b = ~i_a;
            if (k == 12) rst = 1'b0;
            @(posedge clk);
            #1;
            exp = {k == 10 || k == 12, k == 22, 1'b0, 1'b0, k == 20};
            checks++;
            if ({a_press, a_rel, a_click, a_dbl, a_long} !== exp) begin
                errors++;
                $display("FAIL reset_mid edge=%0d: got %b expected %b", k,
                         {a_press, a_rel, a_click, a_dbl, a_long}, exp);
            end
            checks++;
            if (a_held !== (k >= 10 && k <= 21 && k != 11)) begin
                errors++;
                $display("FAIL reset_mid_held edge=%0d: got %b expected %b", k, a_held,
                         (k >= 10 && k <= 21 && k != 11));
            end
            if (k == 10) begin
                #2;
                rst = 1'b1;
                #1;
                checks++;
                if ({a_held, a_press, a_rel, a_click, a_dbl, a_long} !== 6'b0) begin
                    errors++;
                    $display("FAIL reset_async_clear: got %b expected 000000",
                             {a_held, a_press, a_rel, a_click, a_dbl, a_long});
                end
            end
        end
    endtask

    task automatic test_invert_nodbl();
        logic [4:0] exp;
        settle(12);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            i_a = 1'b0;
            i_b = !(k == 10 || k == 11);
            @(posedge clk);
            #1;
            exp = {k == 10, k == 12, k == 12, 1'b0, 1'b0};
            checks++;
            if ({b_press, b_rel, b_click, b_dbl, b_long} !== exp) begin
                errors++;
                $display("FAIL invert_nodbl edge=%0d: got %b expected %b", k,
                         {b_press, b_rel, b_click, b_dbl, b_long}, exp);
            end
        end
    endtask

    task automatic test_random();
        bit lvl;
        int len;
        for (int r = 0; r < 120; r++) begin
            lvl = 1'($urandom_range(0, 1));
            len = (($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 12))
                                               : int'($urandom_range(1, 6)));
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                i_a = lvl;
                i_b = ~lvl;
                rst = ($urandom_range(0, 60) == 0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        settle(12);
    endtask

    initial begin
        test_reset();
        test_single_click();
        test_long_press();
        test_double_click();
        test_gap_boundary();
        test_reset_mid();
        test_invert_nodbl();
        test_random();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_events.md
# button_events

Gesture decoder placed directly downstream of the debouncer. Consumes the debounced, clock-synchronous button level and emits single-cycle event pulses: press, release, single click, double click and long press. Also exports the registered held level. All timing is counted in `clk` cycles. A single FSM and one shared counter implement it.

## Interface
- `LONG_TICKS`, default 50000000: cycles held before `long_o` fires; must be ≥ 2.
- `DOUBLE_TICKS`, default 12500000: maximum release-to-press gap for a double click; 0 disables double-click detection.
- `INVERT`, default 0: 1 means `i` is active-low.
- `clk` in 1: sole clock; everything is on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `i` in 1: debounced button level, synchronous to `clk`.
- `held_o` out 1: registered pressed level.
- `press_o` out 1: pulse, pressed edge.
- `release_o` out 1: pulse, released edge.
- `click_o` out 1: pulse, single click confirmed.
- `dbl_o` out 1: pulse, double click.
- `long_o` out 1: pulse, long press reached.

## Operation
- `lvl = i ^ INVERT`. `prev` is a register holding the last sampled `lvl`; it resets to 0.
- An edge E is a press when `lvl`=1 and `prev`=0; it is a release when `lvl`=0 and `prev`=1.
- `ctr` width is `$clog2(max(LONG_TICKS, DOUBLE_TICKS)+1)`. It saturates and never wraps.
- FSM states: IDLE, DOWN1, GAP, DOWN2, LONG.
  - **IDLE:** on press → DOWN1, `ctr`←0, `press_o`.
  - **DOWN1:**
    - On release: if `DOUBLE_TICKS`≠0 → GAP, `ctr`←0, `release_o`. If `DOUBLE_TICKS`=0 → IDLE, `release_o` and `click_o` together.
    - Otherwise, if `ctr`==`LONG_TICKS`-1 → LONG, `long_o`.
    - Otherwise `ctr`++.
  - **GAP:**
    - On press → DOWN2, `ctr`←0, `press_o`.
    - Otherwise, if `ctr`==`DOUBLE_TICKS`-1 → IDLE, `click_o`.
    - Otherwise `ctr`++.
    - Press has priority over timeout when both occur on the same edge.
  - **DOWN2:**
    - On release → IDLE, `release_o` and `dbl_o` together.
    - If `ctr`==`LONG_TICKS`-1 → LONG, with `click_o` and `long_o` together. The first click is credited and the second press counts as long.
    - Otherwise `ctr`++.
  - **LONG:** on release → IDLE, `release_o` only. No click or double event is emitted.
- At most one of `click_o`/`dbl_o` per gesture.
- `long_o` fires at most once per press.
- `held_o` = `prev`.

## Timing
- All outputs are registered.
- A pulse produced by edge E is high for exactly one cycle, the one following E.
- Press sampled at edge P → `press_o` high after P, `held_o` high after P.
- Continuous hold → `long_o` high after edge P+`LONG_TICKS`.
- Release at edge R in DOWN1, no further press → `click_o` high after edge R+`DOUBLE_TICKS`.
- A press at any edge R+1 … R+`DOUBLE_TICKS` (inclusive) enters DOWN2.
- Reset values: every output 0, `prev` 0, `ctr` 0, state IDLE.
- Assertion of `rst` clears all outputs immediately, regardless of clock. A gesture in progress is discarded with no pulse.
- If `lvl`=1 when `rst` deasserts, the first edge is seen as a press.
- `i` must be glitch-free and synchronous. Metastability handling belongs upstream, in the debouncer.

## Structure
- Package `button_pkg`:
  - `btn_state_t` enum (IDLE, DOWN1, GAP, DOWN2, LONG).
  - `btn_evt_t` packed struct {press, release, click, dbl, long} for consumers that bundle the events.
- One sub-module, `edge_det`. It registers `prev` and produces `rise`/`fall`/`level`, and is reusable elsewhere.
- FSM and counter live in `button_events`.

## Test plan
All cases use `LONG_TICKS`=8, `DOUBLE_TICKS`=5, `INVERT`=0.
- **Single click:** `i` high sampled at edges 10–12, low from 13 → `press_o` after 10, `release_o` after 13, `click_o` after 18. No `dbl_o`/`long_o`.
- **Long press:** `i` high at edges 10–19, low at 20 → `press_o` after 10, `long_o` after 18, `release_o` after 20. No `click_o`.
- **Double click:** high at 10–11, low at 12–14, high at 15–16, low at 17 → `press_o` after 10 and after 15, `release_o` after 12 and after 17, `dbl_o` after 17. No `click_o`.
- **Boundary gap:** release at 12, press at 17 (R+5) → DOWN2, no `click_o`. A press at 18 instead → `click_o` after 17, then `press_o` after 18 from IDLE.
- **Reset mid-gesture:** `rst` pulsed during DOWN1 with `i` still high → outputs 0 immediately, state IDLE. After deassertion, `press_o` after the first edge.
- **`INVERT`=1, `DOUBLE_TICKS`=0:** `i` low at 10–11, high at 12 → `press_o` after 10, `release_o` and `click_o` together after 12.
